dmem_access_ctrl: RTL and testbench

//   Sequences the single data-memory port for the MEM stage of the pipelined core.
//   The port is shared between the CPU load/store (from the EX/MEM register) and a

---
 rtl/dmem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory port sequencer: arbitrates CPU load/store against a debug
// requester, holds the pipeline while the CPU access is in flight, and aborts hung accesses.
module dmem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              err
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    // state      | meaning
    // S_IDLE     | no access in flight, arbitrate
    // S_CPU_BUSY | CPU access outstanding on the memory port
    // S_CPU_DONE | CPU result available, pipeline advances this cycle
    // S_DBG_BUSY | debug access outstanding on the memory port
    // S_DBG_DONE | dbg_ack pulse, dbg_req ignored
    typedef enum logic [2:0] {
        S_IDLE, S_CPU_BUSY, S_CPU_DONE, S_DBG_BUSY, S_DBG_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              last_dbg_q, last_dbg_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              err_q, err_d;
    logic              cpu_pend;
    logic              timeout;

    assign cpu_pend = mem_read | mem_write;
    assign timeout  = (wait_cnt_q == CNT_W'(MAX_WAIT)) && !dm_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_dbg_q  <= 1'b1;
            wait_cnt_q  <= '0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            mem_rdata_q <= '0;
            dbg_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dbg_q  <= last_dbg_d;
            wait_cnt_q  <= wait_cnt_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_dbg_d  = last_dbg_q;
        wait_cnt_d  = wait_cnt_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_wdata_d  = dm_wdata_q;
        mem_rdata_d = mem_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                // On a conflict the side that did not win last time gets the port.
                if (cpu_pend && (!dbg_req || last_dbg_q)) begin
                    state_d    = S_CPU_BUSY;
                    last_dbg_d = 1'b0;
                    wait_cnt_d = '0;
                    dm_req_d   = 1'b1;
                    dm_we_d    = mem_write;
                    dm_addr_d  = mem_addr;
                    dm_wdata_d = mem_wdata;
                end else if (dbg_req) begin
                    state_d    = S_DBG_BUSY;
                    last_dbg_d = 1'b1;
                    wait_cnt_d = '0;
                    dm_req_d   = 1'b1;
                    dm_we_d    = dbg_we;
                    dm_addr_d  = dbg_addr;
                    dm_wdata_d = dbg_wdata;
                end
            end
            S_CPU_BUSY, S_DBG_BUSY: begin
                if (dm_ack || timeout) begin
                    dm_req_d = 1'b0;
                    state_d  = (state_q == S_CPU_BUSY) ? S_CPU_DONE : S_DBG_DONE;
                end
                if (dm_ack) begin
                    if (!dm_we_q && state_q == S_CPU_BUSY) mem_rdata_d = dm_rdata;
                    if (!dm_we_q && state_q == S_DBG_BUSY) dbg_rdata_d = dm_rdata;
                end else if (timeout) begin
                    err_d = 1'b1;
                    if (state_q == S_CPU_BUSY) mem_rdata_d = '0;
                    else                       dbg_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_CPU_DONE, S_DBG_DONE: state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall   = reset & cpu_pend & (state_q != S_CPU_DONE);
        dbg_ack = (state_q == S_DBG_DONE);
    end

    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign mem_rdata = mem_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dmem_access_ctrl;
    localparam int MAX_WAIT = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        err;

    int total = 0;
    int bad = 0;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the port, whether this is its completion cycle,
    // and how many busy cycles have elapsed.
    int          m_owner = 0;          // 0 none, 1 cpu, 2 debug
    bit          m_done = 1'b0;
    bit          m_last_dbg = 1'b1;
    bit          m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
    int          m_busy = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_mrd = '0, m_drd = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_owner = 0; m_done = 1'b0; m_last_dbg = 1'b1; m_req = 1'b0; m_we = 1'b0;
            m_err = 1'b0; m_busy = 0; m_addr = '0; m_wdata = '0; m_mrd = '0; m_drd = '0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_owner = 0;
        end else if (m_owner == 0) begin
            if ((mem_read | mem_write) && (!dbg_req || m_last_dbg)) begin
                m_owner = 1; m_last_dbg = 1'b0; m_req = 1'b1; m_busy = 0;
                m_we = mem_write; m_addr = mem_addr; m_wdata = mem_wdata;
            end else if (dbg_req) begin
                m_owner = 2; m_last_dbg = 1'b1; m_req = 1'b1; m_busy = 0;
                m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
            end
        end else begin
            m_busy++;
            if (dm_ack) begin
                m_req = 1'b0; m_done = 1'b1;
                if (!m_we) begin
                    if (m_owner == 1) m_mrd = dm_rdata;
                    else              m_drd = dm_rdata;
                end
            end else if (m_busy > MAX_WAIT) begin
                m_req = 1'b0; m_done = 1'b1; m_err = 1'b1;
                if (m_owner == 1) m_mrd = '0;
                else              m_drd = '0;
            end
        end
    end

    // Memory responder: acks ack_lat cycles after the request appears (-1 = never).
    int          ack_lat = 0;
    int          busy_n = 0;
    logic [31:0] rd_val = '0;
    bit          spur_ack = 1'b0;

    always @(negedge clock) begin
        #1;
        dm_rdata = rd_val;
        if (m_req) begin
            dm_ack = (ack_lat >= 0) && (busy_n == ack_lat);
            busy_n++;
        end else begin
            dm_ack = spur_ack;
            busy_n = 0;
        end
    end

    always @(negedge clock) begin
        chk("stall", 32'(stall), 32'(reset & (mem_read | mem_write) & !(m_done && m_owner == 1)));
        chk("dm_req", 32'(dm_req), 32'(m_req));
        chk("dm_we", 32'(dm_we), 32'(m_we));
        chk("dm_addr", dm_addr, m_addr);
        chk("dm_wdata", dm_wdata, m_wdata);
        chk("mem_rdata", mem_rdata, m_mrd);
        chk("dbg_ack", 32'(dbg_ack), 32'(m_done && m_owner == 2));
        chk("dbg_rdata", dbg_rdata, m_drd);
        chk("err", 32'(err), 32'(m_err));
    end

    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int n;
        bit prev_req;
        logic [31:0] grants[$];
        logic [31:0] rr_exp[3];

        nxt(); nxt();
        chk("rst_dm_req", 32'(dm_req), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_dbg_ack", 32'(dbg_ack), 0);
        mem_read = 1'b1; mem_addr = 32'h40; rd_val = 32'hDEADBEEF; ack_lat = 2;
        #1 chk("stall_in_reset", 32'(stall), 0);

        // CPU load, ack two cycles after dm_req rises
        nxt(); reset = 1'b1;
        #1 chk("stall_at_release", 32'(stall), 1);
        n = 1;
        nxt();
        chk("load_dm_req", 32'(dm_req), 1);
        chk("load_dm_addr", dm_addr, 32'h40);
        chk("load_dm_we", 32'(dm_we), 0);
        while (stall && n < 40) begin n++; nxt(); end
        chk("load_stall_cycles", n, 4);
        chk("load_mem_rdata", mem_rdata, 32'hDEADBEEF);
        mem_read = 1'b0;

        // Debug write alone, dbg_req held through the ack cycle
        nxt();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h55; ack_lat = 1;
        n = 0;
        while (!dbg_ack && n < 30) begin nxt(); n++; end
        chk("dbgw_ack", 32'(dbg_ack), 1);
        chk("dbgw_dm_addr", dm_addr, 32'h20);
        chk("dbgw_rdata_held", dbg_rdata, 0);
        nxt();
        chk("dbg_no_dup", 32'(dm_req), 0);
        dbg_req = 1'b0;
        nxt();
        chk("dbg_no_dup2", 32'(dm_req), 0);

        // Conflict: CPU store against debug read, CPU first
        mem_write = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h12345678;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10; ack_lat = 0; rd_val = 32'hA5A50001;
        nxt();
        chk("conf_dm_we", 32'(dm_we), 1);
        chk("conf_dm_addr", dm_addr, 32'h80);
        chk("conf_dm_wdata", dm_wdata, 32'h12345678);
        nxt();
        chk("conf_stall_done", 32'(stall), 0);
        chk("store_holds_rdata", mem_rdata, 32'hDEADBEEF);
        mem_write = 1'b0;
        n = 0;
        while (!dbg_ack && n < 30) begin nxt(); n++; end
        chk("conf_dbg_ack", 32'(dbg_ack), 1);
        chk("conf_dbg_rdata", dbg_rdata, 32'hA5A50001);
        dbg_req = 1'b0;

        // Persistent conflict: grants alternate CPU, DBG, CPU
        nxt();
        mem_read = 1'b1; mem_addr = 32'hC0; dbg_req = 1'b1; dbg_addr = 32'hD0;
        ack_lat = 1; rd_val = 32'h0BADF00D;
        prev_req = 1'b0; n = 0;
        while (grants.size() < 3 && n < 60) begin
            nxt(); n++;
            if (dm_req && !prev_req) grants.push_back(dm_addr);
            prev_req = dm_req;
        end
        dbg_req = 1'b0;
        rr_exp[0] = 32'hC0; rr_exp[1] = 32'hD0; rr_exp[2] = 32'hC0;
        chk("rr_count", grants.size(), 3);
        for (int i = 0; i < grants.size() && i < 3; i++) chk("rr_order", grants[i], rr_exp[i]);
        n = 0;
        while (stall && n < 20) begin nxt(); n++; end
        mem_read = 1'b0;

        // Time-out on a CPU load; err is sticky
        nxt();
        mem_read = 1'b1; mem_addr = 32'h100; ack_lat = -1;
        #1 n = 0;
        while (stall && n < 40) begin n++; nxt(); end
        chk("to_stall_cycles", n, 17);
        chk("to_err", 32'(err), 1);
        chk("to_mem_rdata", mem_rdata, 0);
        chk("to_dm_req", 32'(dm_req), 0);
        mem_read = 1'b0; spur_ack = 1'b1;
        repeat (3) nxt();
        chk("spur_ack_ignored", 32'(dm_req), 0);
        chk("err_sticky", 32'(err), 1);
        spur_ack = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30; ack_lat = 0; rd_val = 32'h77;
        n = 0;
        while (!dbg_ack && n < 30) begin nxt(); n++; end
        chk("post_to_dbg_rdata", dbg_rdata, 32'h77);
        chk("err_still_set", 32'(err), 1);
        dbg_req = 1'b0;

        // Reset in the middle of a debug access
        nxt();
        dbg_req = 1'b1; dbg_addr = 32'hE0; ack_lat = -1;
        repeat (3) nxt();
        chk("dbg_busy_req", 32'(dm_req), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_dm_req", 32'(dm_req), 0);
        chk("mid_rst_dbg_ack", 32'(dbg_ack), 0);
        chk("mid_rst_err", 32'(err), 0);
        mem_read = 1'b1; mem_addr = 32'hF0; ack_lat = 0;
        nxt(); reset = 1'b1;
        nxt();
        chk("cpu_first_after_rst", dm_addr, 32'hF0);
        nxt();
        mem_read = 1'b0;
        n = 0;
        while (!dbg_ack && n < 30) begin nxt(); n++; end
        chk("dbg_after_rst_ack", 32'(dbg_ack), 1);
        dbg_req = 1'b0;
        repeat (3) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
